mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that drives the select and active-low enable pins of a dual 4-to-1 tri-state multiplexer stage and collects its two outputs. One scan steps the select through 0..3 and recovers both 4-bit input nibbles as one 8-bit word. The word is presented downstream on a valid/ready handshake. The block sits directly around the mux: it is the mux's upstream control source and its downstream consumer.

## Interface
- SETTLE_CYCLES, default 1: clock cycles per select code between select change and sample; legal range 1..15.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin one scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled only at a handshake completion.
- abort  input  1  synchronous abort; scan is discarded.
- S0  output  1  mux select bit 0.
- S1  output  1  mux select bit 1.
- G1_n  output  1  channel-1 enable, active low.
- G2_n  output  1  channel-2 enable, active low.
- Y1  input  1  mux channel-1 output.
- Y2  input  1  mux channel-2 output.
- data  output  8  scanned word, {D2[3:0], D1[3:0]}.
- valid  output  1  data is held for the consumer.
- ready  input  1  consumer accepts data.
- busy  output  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, SETTLE, HOLD.
- **IDLE outputs:**
  - G1_n = G2_n = 1, so both mux outputs are released.
  - {S1,S0} = 00; valid = 0; busy = 0.
  - data keeps its last value (0 after reset).
- **IDLE, start = 1:** go to SETTLE with idx = 0 and settle counter = 0.
- **SETTLE outputs:**
  - {S1,S0} = idx; G1_n = G2_n = 0.
  - The counter increments each cycle.
- **SETTLE sample edge:** the edge at which the counter equals SETTLE_CYCLES-1.
  - Capture data[idx] ← Y1 and data[4+idx] ← Y2.
  - Clear the counter.
  - If idx = 3, go to HOLD; otherwise idx ← idx+1.
- **HOLD outputs:** valid = 1; G1_n = G2_n = 1; {S1,S0} = 11; data stable.
- **HOLD, valid & ready at an edge:**
  - cont = 1: go to SETTLE with idx = 0.
  - cont = 0: go to IDLE.
- **Data ownership:** data is written only at sample edges. Bits not yet resampled in a new scan keep their previous values. The consumer reads data only while valid = 1.
- **Abort:** abort = 1 in SETTLE or HOLD → IDLE at the next edge.
  - valid drops and enables return high.
  - Already captured bits remain in data; no transfer occurs.
  - Abort has priority over the handshake and over sampling on the same edge.
- **start while busy:** ignored.
- **Reset:** rst_n = 0 at any time, including mid-scan.
  - State → IDLE immediately (asynchronous); idx = 0; counter = 0; data = 8'h00.
  - valid = 0; busy = 0; G1_n = G2_n = 1; S1 = S0 = 0.

## Timing
- Let E0 be the edge at which start is sampled in IDLE.
- Select code k is driven from E0 + k·SETTLE_CYCLES.
- Select code k is sampled at E0 + (k+1)·SETTLE_CYCLES.
- valid rises after E0 + 4·SETTLE_CYCLES. With SETTLE_CYCLES = 1 that is 4 cycles.
- ready may be high before valid; the transfer then occurs at the first edge with valid = 1.
- Continuous mode: the next scan's select 00 is driven in the cycle after the transfer edge.
  - Period = 4·SETTLE_CYCLES + 1 cycles with ready held high.
- Enables are low only in SETTLE, so Y1/Y2 are never sampled while the mux outputs are high-impedance.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package mux_scan_pkg:
  - state typedef enum {IDLE, SETTLE, HOLD};
  - constant SEL_LAST = 2'd3;
  - constant MAX_SETTLE = 15.
- Single module; the 4-bit settle counter and 2-bit idx are inline. No sub-module.
- SETTLE_CYCLES is range-checked by an elaboration-time assertion.

## Test plan
- **Single scan:** SETTLE_CYCLES = 1, mux D1 = 4'b1010, D2 = 4'b0110, ready = 1, pulse start → S sequence 00,01,10,11, one per cycle, with G1_n = G2_n = 0; valid rises 4 cycles after the start edge with data = 8'h6A; IDLE one cycle later.
- **Backpressure:** SETTLE_CYCLES = 3, D1 = 4'hF, D2 = 4'h0, ready = 0 → valid rises after 12 cycles; data = 8'h0F held and enables high for 10 cycles; ready = 1 → one transfer, then IDLE.
- **Continuous:** cont = 1, ready = 1, D1/D2 changed between scans (8'h21, then 8'h43) → consecutive words 8'h21, 8'h43 with a 5-cycle period at SETTLE_CYCLES = 1; cont = 0 at the second handshake → IDLE.
- **Abort and start-while-busy:** abort asserted at select 10 → IDLE next edge with no valid pulse and G_n high; start pulsed while busy → no restart.
- **Async reset mid-HOLD:** reset while valid = 1 → valid, busy and data go to 0 and G1_n = G2_n = 1 before the next clock edge.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and limits for the dual 4:1 mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_e;

    localparam logic [1:0] SEL_LAST   = 2'd3;
    localparam int         MAX_SETTLE = 15;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Steps a dual 4:1 tri-state mux through all selects and
// assembles both channels into one word on a valid/ready port.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    output logic       S0,
    output logic       S1,
    output logic       G1_n,
    output logic       G2_n,
    input  logic       Y1,
    input  logic       Y2,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 1..15");
    end

    localparam logic [3:0] SAMPLE_AT = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Abort wins over both sampling and the handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                end else if (cnt_q == SAMPLE_AT) begin
                    data_d[{1'b0, idx_q}] = Y1;
                    data_d[{1'b1, idx_q}] = Y2;
                    cnt_d = 4'd0;
                    if (idx_q == SEL_LAST) begin
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end else if (ready) begin
                    state_d = cont ? SETTLE : IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        {S1, S0} = 2'b00;
        G1_n     = 1'b1;
        G2_n     = 1'b1;
        valid    = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            SETTLE: begin
                {S1, S0} = idx_q;
                G1_n     = 1'b0;
                G2_n     = 1'b0;
                busy     = 1'b1;
            end
            HOLD: begin
                {S1, S0} = SEL_LAST;
                valid    = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: instance 0 settles 1 cycle,
// instance 1 settles 3 cycles; both drive a behavioural mux.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start [2];
    logic       cont  [2];
    logic       abort [2];
    logic       ready [2];
    logic       s0    [2];
    logic       s1    [2];
    logic       g1n   [2];
    logic       g2n   [2];
    logic       y1    [2];
    logic       y2    [2];
    logic       valid [2];
    logic       busy  [2];
    logic [7:0] data  [2];
    logic [3:0] d1    [2];
    logic [3:0] d2    [2];

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .cont(cont[0]),
        .abort(abort[0]), .S0(s0[0]), .S1(s1[0]), .G1_n(g1n[0]),
        .G2_n(g2n[0]), .Y1(y1[0]), .Y2(y2[0]), .data(data[0]),
        .valid(valid[0]), .ready(ready[0]), .busy(busy[0])
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .cont(cont[1]),
        .abort(abort[1]), .S0(s0[1]), .S1(s1[1]), .G1_n(g1n[1]),
        .G2_n(g2n[1]), .Y1(y1[1]), .Y2(y2[1]), .data(data[1]),
        .valid(valid[1]), .ready(ready[1]), .busy(busy[1])
    );

    // Released mux outputs read as 0 here.
    assign y1[0] = g1n[0] ? 1'b0 : d1[0][{s1[0], s0[0]}];
    assign y2[0] = g2n[0] ? 1'b0 : d2[0][{s1[0], s0[0]}];
    assign y1[1] = g1n[1] ? 1'b0 : d1[1][{s1[1], s0[1]}];
    assign y2[1] = g2n[1] ? 1'b0 : d2[1][{s1[1], s0[1]}];

    int vec_n  = 0;
    int miss_n = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfers happen at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n && valid[0] && ready[0]) begin
            if (q0.size() == 0) check("u1 unexpected xfer", 1, 0);
            else check("u1 xfer data", {24'h0, data[0]}, {24'h0, q0.pop_front()});
        end
        if (rst_n && valid[1] && ready[1]) begin
            if (q1.size() == 0) check("u3 unexpected xfer", 1, 0);
            else check("u3 xfer data", {24'h0, data[1]}, {24'h0, q1.pop_front()});
        end
    end

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{4'hA, 4'h6, 8'h6A};
        vecs[1] = '{4'h0, 4'h0, 8'h00};
        vecs[2] = '{4'hF, 4'hF, 8'hFF};
        vecs[3] = '{4'h5, 4'hC, 8'hC5};
        vecs[4] = '{4'h3, 4'h9, 8'h93};
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; cont[i] = 0; abort[i] = 0;
            ready[i] = 0; d1[i] = 0; d2[i] = 0;
        end

        repeat (2) tick();
        check("reset u1 outs",
              {valid[0], busy[0], g1n[0], g2n[0], s1[0], s0[0], data[0]},
              {6'b001100, 8'h00});
        check("reset u3 outs",
              {valid[1], busy[1], g1n[1], g2n[1], s1[1], s0[1], data[1]},
              {6'b001100, 8'h00});
        rst_n = 1;
        tick();

        // Single scans, SETTLE_CYCLES=1, ready held high.
        for (int v = 0; v < 5; v++) begin
            d1[0] = vecs[v].d1;
            d2[0] = vecs[v].d2;
            ready[0] = 1;
            start[0] = 1;
            q0.push_back(vecs[v].exp);
            tick();
            start[0] = 0;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("v%0d sel%0d", v, k),
                      {s1[0], s0[0], g1n[0], g2n[0], valid[0]},
                      {k[1:0], 3'b000});
                tick();
            end
            check($sformatf("v%0d hold", v),
                  {valid[0], g1n[0], g2n[0], s1[0], s0[0], data[0]},
                  {5'b11111, vecs[v].exp});
            tick();
            check($sformatf("v%0d idle", v),
                  {busy[0], valid[0], g1n[0], g2n[0]}, 4'b0011);
        end
        ready[0] = 0;
        tick();
        check("idle keeps data", {24'h0, data[0]}, 32'h93);

        // Backpressure, SETTLE_CYCLES=3.
        d1[1] = 4'hF; d2[1] = 4'h0;
        start[1] = 1;
        q1.push_back(8'h0F);
        tick();
        start[1] = 0;
        repeat (11) tick();
        check("bp no valid at 11", {31'h0, valid[1]}, 0);
        tick();
        check("bp valid at 12", {valid[1], data[1]}, {1'b1, 8'h0F});
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp hold c%0d", c),
                  {valid[1], g1n[1], g2n[1], data[1]}, {3'b111, 8'h0F});
        end
        ready[1] = 1;
        tick();
        check("bp idle", {busy[1], valid[1]}, 2'b00);
        ready[1] = 0;

        // Continuous mode, two words back to back.
        d1[0] = 4'h1; d2[0] = 4'h2;
        cont[0] = 1; ready[0] = 1; start[0] = 1;
        q0.push_back(8'h21);
        q0.push_back(8'h43);
        tick();
        start[0] = 0;
        repeat (3) tick();
        tick();
        check("cont word1", {valid[0], data[0]}, {1'b1, 8'h21});
        d1[0] = 4'h3; d2[0] = 4'h4;
        tick();
        check("cont rescan", {busy[0], valid[0], s1[0], s0[0], g1n[0]},
              5'b10000);
        cont[0] = 0;
        repeat (3) tick();
        tick();
        check("cont word2", {valid[0], data[0]}, {1'b1, 8'h43});
        tick();
        check("cont idle", {busy[0], valid[0]}, 2'b00);
        ready[0] = 0;

        // Abort at select 10, with a start pulse while busy.
        d1[0] = 4'hA; d2[0] = 4'h6;
        ready[0] = 1;
        start[0] = 1;
        tick();
        start[0] = 0;
        tick();
        start[0] = 1;
        tick();
        start[0] = 0;
        check("no restart", {s1[0], s0[0], busy[0]}, 3'b101);
        abort[0] = 1;
        tick();
        abort[0] = 0;
        check("abort idle", {busy[0], valid[0], g1n[0], g2n[0]}, 4'b0011);
        check("abort partial data", {24'h0, data[0]}, 32'h62);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("abort quiet c%0d", c),
                  {busy[0], valid[0]}, 2'b00);
        end
        ready[0] = 0;

        // Asynchronous reset while holding a word.
        d1[1] = 4'h5; d2[1] = 4'hA;
        start[1] = 1;
        tick();
        start[1] = 0;
        n = 0;
        while (!valid[1] && n < 30) begin
            tick();
            n++;
        end
        check("rst pre valid", {valid[1], data[1]}, {1'b1, 8'hA5});
        #2 rst_n = 0;
        #1;
        check("async rst u3",
              {valid[1], busy[1], g1n[1], g2n[1], s1[1], s0[1], data[1]},
              {6'b001100, 8'h00});
        check("async rst u1 data", {24'h0, data[0]}, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) tick();

        check("u1 queue drained", q0.size(), 0);
        check("u3 queue drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
